// File: rtl/trivium_seq.sv
// Sequencer between a host and a Trivium core: serial key load, plaintext feed,
// keystream burst collection, per-key burst limit and a watchdog on every core wait.
module trivium_seq #(
  parameter int unsigned KEY_BITS     = 80,
  parameter int unsigned BURST_LEN    = 256,
  parameter int unsigned REKEY_BURSTS = 1024,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_load,
  input  logic [7:0]          pt_data,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [1:0]          sink_full,
  output logic [7:0]          ct_data,
  output logic                ct_valid,
  output logic                busy,
  output logic                rekey_req,
  output logic                err,
  output logic                core_key,
  output logic                core_strob_key,
  output logic [7:0]          core_data,
  output logic                core_strob_data,
  output logic [1:0]          core_fifo_cnd,
  input  logic [7:0]          core_stream,
  input  logic                core_wt_sgn,
  input  logic [7:0]          core_status
);

  localparam int unsigned KCNT_W = $clog2(KEY_BITS);
  localparam int unsigned OCNT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned BCNT_W = $clog2(REKEY_BURSTS + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_SHIFT,
    S_WAIT_INIT,
    S_READY,
    S_BURST,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [KEY_BITS-1:0] r_key;
  logic [KCNT_W-1:0]   r_kcnt;
  logic [OCNT_W-1:0]   r_ocnt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [WD_W-1:0]     r_wd;

  logic       r_pt_ready;
  logic [7:0] r_ct_data;
  logic       r_ct_valid;
  logic       r_busy;
  logic       r_rekey_req;
  logic       r_err;
  logic       r_core_key;
  logic       r_strob_key;
  logic [7:0] r_core_data;
  logic       r_strob_data;
  logic [1:0] r_fifo_cnd;

  logic w_wait_data;
  logic w_counting;
  logic w_timeout;
  logic w_fault;
  logic w_unused;

  assign w_wait_data = core_status[2];
  assign w_unused    = ^{core_status[7:6], core_status[4:3], core_status[1:0]};

  // Watchdog advances only while the awaited core event is absent (and the sink is not stalling)
  always_comb begin
    w_counting = 1'b0;
    case (r_state)
      S_WAIT_INIT: w_counting = !w_wait_data;
      S_BURST:     w_counting = !core_wt_sgn;
      S_DRAIN:     w_counting = !w_wait_data && (sink_full == 2'b00);
      default:     w_counting = 1'b0;
    endcase
  end

  assign w_timeout = w_counting && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_fault   = (r_state != S_ERROR) && (core_status[5] || w_timeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_kcnt       <= '0;
      r_ocnt       <= '0;
      r_bcnt       <= '0;
      r_wd         <= '0;
      r_pt_ready   <= 1'b0;
      r_ct_data    <= '0;
      r_ct_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_rekey_req  <= 1'b0;
      r_err        <= 1'b0;
      r_core_key   <= 1'b0;
      r_strob_key  <= 1'b0;
      r_core_data  <= '0;
      r_strob_data <= 1'b0;
      r_fifo_cnd   <= '0;
    end else begin
      r_fifo_cnd   <= sink_full;
      r_strob_data <= 1'b0;
      r_ct_valid   <= 1'b0;
      if (w_fault) begin
        r_state     <= S_ERROR;
        r_err       <= 1'b1;
        r_busy      <= 1'b0;
        r_pt_ready  <= 1'b0;
        r_strob_key <= 1'b0;
        r_core_key  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_ERROR: begin
            if (key_load) begin
              r_key       <= key_in;
              r_core_key  <= key_in[KEY_BITS-1];
              r_strob_key <= 1'b1;
              r_kcnt      <= '0;
              r_bcnt      <= '0;
              r_busy      <= 1'b1;
              r_err       <= 1'b0;
              r_rekey_req <= 1'b0;
              r_state     <= S_KEY_SHIFT;
            end
          end
          S_KEY_SHIFT: begin
            if (r_kcnt == KCNT_W'(KEY_BITS - 1)) begin
              r_strob_key <= 1'b0;
              r_core_key  <= 1'b0;
              r_wd        <= '0;
              r_state     <= S_WAIT_INIT;
            end else begin
              r_kcnt     <= r_kcnt + KCNT_W'(1);
              r_core_key <= r_key[KEY_BITS-2];
              r_key      <= {r_key[KEY_BITS-2:0], 1'b0};
            end
          end
          S_WAIT_INIT: begin
            if (w_wait_data) begin
              r_pt_ready <= 1'b1;
              r_state    <= S_READY;
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
          end
          S_READY: begin
            if (pt_valid) begin
              r_core_data  <= pt_data;
              r_strob_data <= 1'b1;
              r_pt_ready   <= 1'b0;
              r_ocnt       <= '0;
              r_wd         <= '0;
              r_state      <= S_BURST;
            end
          end
          S_BURST: begin
            if (core_wt_sgn) begin
              r_ct_data  <= core_stream;
              r_ct_valid <= 1'b1;
              r_ocnt     <= r_ocnt + OCNT_W'(1);
              r_wd       <= '0;
              if (r_ocnt == OCNT_W'(BURST_LEN - 1)) begin
                if (r_bcnt != BCNT_W'(REKEY_BURSTS)) r_bcnt <= r_bcnt + BCNT_W'(1);
                r_state <= S_DRAIN;
              end
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
          end
          S_DRAIN: begin
            if (w_wait_data) begin
              if (r_bcnt == BCNT_W'(REKEY_BURSTS)) begin
                r_rekey_req <= 1'b1;
                r_bcnt      <= '0;
                r_busy      <= 1'b0;
                r_state     <= S_IDLE;
              end else begin
                r_pt_ready <= 1'b1;
                r_state    <= S_READY;
              end
            end else if (sink_full == 2'b00) begin
              r_wd <= r_wd + WD_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pt_ready        = r_pt_ready;
  assign ct_data         = r_ct_data;
  assign ct_valid        = r_ct_valid;
  assign busy            = r_busy;
  assign rekey_req       = r_rekey_req;
  assign err             = r_err;
  assign core_key        = r_core_key;
  assign core_strob_key  = r_strob_key;
  assign core_data       = r_core_data;
  assign core_strob_data = r_strob_data;
  assign core_fifo_cnd   = r_fifo_cnd;

endmodule
